// File: rtl/demux_dispatch_pkg.sv
// Shared types and constants for the four-lane dispatch controller.
package demux_dispatch_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;

    localparam logic MODE_RR       = 1'b0;
    localparam logic MODE_EXPLICIT = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } dispatch_state_e;

    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
        return NUM_LANES'(1) << lane;
    endfunction

endpackage

// File: rtl/dispatch_sat_cnt.sv
// Saturating transfer counter with a synchronous clear that beats increment.
module dispatch_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Single-entry dispatcher: captures one word and steers it to one of four
// lanes (round-robin or explicit); valid/ready on both sides, per-lane counters.
module demux_dispatch_ctrl
    import demux_dispatch_pkg::*;
#(
    parameter int N     = 3,
    parameter int CNT_W = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [N:0]                        in_data_i,
    input  logic [LANE_W-1:0]                 in_dest_i,
    input  logic                              mode_i,
    output logic [NUM_LANES-1:0]              out_valid_o,
    input  logic [NUM_LANES-1:0]              out_ready_i,
    output logic [NUM_LANES-1:0][N:0]         out_data_o,
    output logic [LANE_W-1:0]                 sel_o,
    output logic                              busy_o,
    input  logic                              clr_cnt_i,
    output logic [NUM_LANES-1:0][CNT_W-1:0]   lane_cnt_o
);

    // Handshake rule (both sides): a word moves on a rising edge where valid
    // and ready are both high. Once out_valid_o rises it stays high with
    // stable data until the selected lane's ready completes the transfer.

    dispatch_state_e     r_state;
    dispatch_state_e     w_state_nxt;
    logic [N:0]          r_data;
    logic [LANE_W-1:0]   r_sel;
    logic [LANE_W-1:0]   r_rr_ptr;
    logic                w_drain;
    logic                w_capture;
    logic                w_ready_raw;

    assign w_drain = (r_state == HOLD) && out_ready_i[r_sel];

    // Readiness in HOLD follows the selected lane so a drain and a new
    // capture can share one edge; reset gates it off asynchronously.
    assign w_ready_raw = (r_state == IDLE) ? 1'b1 : out_ready_i[r_sel];
    assign in_ready_o  = rst_ni && w_ready_raw;
    assign w_capture   = in_valid_i && in_ready_o;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_capture) w_state_nxt = HOLD;
            HOLD: if (w_drain && !w_capture) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_data   <= '0;
            r_sel    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_data <= in_data_i;
                r_sel  <= (mode_i == MODE_EXPLICIT) ? in_dest_i : r_rr_ptr;
                if (mode_i == MODE_RR) begin
                    r_rr_ptr <= r_rr_ptr + LANE_W'(1);
                end
            end
        end
    end

    always_comb begin
        out_valid_o = '0;
        out_data_o  = '0;
        if (r_state == HOLD) begin
            out_valid_o       = lane_onehot(r_sel);
            out_data_o[r_sel] = r_data;
        end
    end

    assign busy_o = (r_state == HOLD);
    assign sel_o  = r_sel;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane_cnt
        dispatch_sat_cnt #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .inc_i  (w_drain && (r_sel == LANE_W'(g))),
            .clr_i  (clr_cnt_i),
            .cnt_o  (lane_cnt_o[g])
        );
    end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Bench for demux_dispatch_ctrl: directed vector table, hand-written corner
// sequences and random traffic against a lane/queue reference model.
module tb_demux_dispatch_ctrl;
  import demux_dispatch_pkg::*;

  localparam int N       = 3;
  localparam int CNT_W   = 8;
  localparam int CNT_W_S = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic                   in_valid;
  logic [N:0]             in_data;
  logic [1:0]             in_dest;
  logic                   mode;
  logic [3:0]             out_ready;
  logic                   clr;

  logic                   in_ready;
  logic [3:0]             out_valid;
  logic [3:0][N:0]        out_data;
  logic [1:0]             sel;
  logic                   busy;
  logic [3:0][CNT_W-1:0]  lane_cnt;

  logic                   s_in_ready;
  logic [3:0]             s_out_valid;
  logic [3:0][N:0]        s_out_data;
  logic [1:0]             s_sel;
  logic                   s_busy;
  logic [3:0][CNT_W_S-1:0] s_lane_cnt;

  demux_dispatch_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_dest_i(in_dest), .mode_i(mode),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .sel_o(sel), .busy_o(busy), .clr_cnt_i(clr), .lane_cnt_o(lane_cnt)
  );

  // Same stimulus, narrow counters, to reach saturation quickly.
  demux_dispatch_ctrl #(.N(N), .CNT_W(CNT_W_S)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
    .in_data_i(in_data), .in_dest_i(in_dest), .mode_i(mode),
    .out_valid_o(s_out_valid), .out_ready_i(out_ready), .out_data_o(s_out_data),
    .sel_o(s_sel), .busy_o(s_busy), .clr_cnt_i(clr), .lane_cnt_o(s_lane_cnt)
  );

  // ---------------- reference model + scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  bit  m_held;
  int  m_lane, m_data, m_rr, m_sel;
  int  m_cnt[4];
  logic [5:0] exp_q[$];

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_lane = 0; m_data = 0; m_rr = 0; m_sel = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    exp_q.delete();
  endtask

  task automatic check_model();
    logic            er;
    logic [3:0]      ev;
    logic [3:0][N:0] ed;
    er = rst_n && (!m_held || out_ready[m_lane]);
    ev = m_held ? (4'b0001 << m_lane) : 4'b0000;
    ed = '0;
    if (m_held) ed[m_lane] = m_data[N:0];
    chk("in_ready", in_ready, er);
    chk("out_valid", out_valid, ev);
    chk("out_data", out_data, ed);
    chk("sel", sel, m_sel);
    chk("busy", busy, m_held);
    chk("s_out_valid", s_out_valid, ev);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lane_cnt%0d", i), lane_cnt[i], sat(m_cnt[i], 255));
      chk($sformatf("s_lane_cnt%0d", i), s_lane_cnt[i], sat(m_cnt[i], 3));
    end
  endtask

  task automatic scoreboard();
    int dl;
    logic [5:0] got;
    if (m_held && out_ready[m_lane] && rst_n) begin
      dl = 0;
      for (int k = 0; k < 4; k++) if (out_valid[k]) dl = k;
      got = {2'(dl), out_data[dl]};
      if (exp_q.size() == 0) chk("scb_nonempty", 1'b0, 1'b1);
      else chk("scb_word", got, exp_q.pop_front());
    end
  endtask

  task automatic model_step();
    bit drain, cap;
    int lane;
    drain = rst_n && m_held && out_ready[m_lane];
    cap   = rst_n && in_valid && (!m_held || out_ready[m_lane]);
    if (clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    else if (drain) m_cnt[m_lane]++;
    if (cap) begin
      lane = mode ? int'(in_dest) : m_rr;
      exp_q.push_back({2'(lane), in_data});
      m_held = 1; m_lane = lane; m_data = int'(in_data); m_sel = lane;
      if (!mode) m_rr = (m_rr + 1) % 4;
    end else if (drain) begin
      m_held = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [N:0] d, input logic [1:0] dst,
                       input logic md, input logic [3:0] rdy, input logic c);
    in_valid = v; in_data = d; in_dest = dst; mode = md; out_ready = rdy; clr = c;
    #1;
  endtask

  task automatic close_cycle();
    check_model();
    scoreboard();
    model_step();
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       v;
    logic [N:0] d;
    logic       exp_rdy;
    logic [3:0] exp_valid;
    logic [N:0] exp_data;
    logic [1:0] exp_sel;
    logic       exp_busy;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [3:0][N:0] ed;
    logic [CNT_W-1:0] c1_before;

    tbl[0] = '{1'b1, 4'd1, 1'b1, 4'b0000, 4'd0, 2'd0, 1'b0};
    tbl[1] = '{1'b1, 4'd2, 1'b1, 4'b0001, 4'd1, 2'd0, 1'b1};
    tbl[2] = '{1'b1, 4'd3, 1'b1, 4'b0010, 4'd2, 2'd1, 1'b1};
    tbl[3] = '{1'b1, 4'd4, 1'b1, 4'b0100, 4'd3, 2'd2, 1'b1};
    tbl[4] = '{1'b1, 4'd5, 1'b1, 4'b1000, 4'd4, 2'd3, 1'b1};
    tbl[5] = '{1'b0, 4'd0, 1'b1, 4'b0001, 4'd5, 2'd0, 1'b1};
    tbl[6] = '{1'b0, 4'd0, 1'b1, 4'b0000, 4'd0, 2'd0, 1'b0};

    // reset state
    rst_n = 1'b0;
    model_reset();
    drive(1'b0, '0, 2'd0, MODE_RR, 4'h0, 1'b0);
    chk("reset_in_ready", in_ready, 1'b0);
    close_cycle();
    close_cycle();
    rst_n = 1'b1;

    // round-robin streaming, one word per cycle
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].v, tbl[i].d, 2'd0, MODE_RR, 4'hF, 1'b0);
      ed = '0;
      for (int k = 0; k < 4; k++) if (tbl[i].exp_valid[k]) ed[k] = tbl[i].exp_data;
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_out_data", i), out_data, ed);
      chk($sformatf("tbl%0d_sel", i), sel, tbl[i].exp_sel);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      close_cycle();
    end
    chk("rr_cnt0", lane_cnt[0], 8'd2);
    chk("rr_cnt1", lane_cnt[1], 8'd1);
    chk("rr_cnt2", lane_cnt[2], 8'd1);
    chk("rr_cnt3", lane_cnt[3], 8'd1);

    // stalled lane: explicit dest 2, lane 2 not ready for 5 cycles
    drive(1'b1, 4'hA, 2'd2, MODE_EXPLICIT, 4'b1011, 1'b0);
    close_cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'h3, 2'd0, MODE_RR, 4'b1011, 1'b0);
      chk("stall_valid", out_valid, 4'b0100);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_data", out_data, 16'h0A00);
      close_cycle();
    end
    drive(1'b0, 4'h0, 2'd0, MODE_RR, 4'b0100, 1'b0);
    chk("stall_release_ready", in_ready, 1'b1);
    close_cycle();
    drive(1'b0, 4'h0, 2'd0, MODE_RR, 4'hF, 1'b0);
    chk("stall_done_busy", busy, 1'b0);
    chk("stall_done_cnt2", lane_cnt[2], 8'd2);
    close_cycle();

    // asynchronous reset while holding 7 on lane 2
    drive(1'b1, 4'h7, 2'd2, MODE_EXPLICIT, 4'h0, 1'b0);
    close_cycle();
    drive(1'b0, 4'h0, 2'd0, MODE_RR, 4'h0, 1'b0);
    chk("pre_rst_valid", out_valid, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 4'b0000);
    chk("arst_data", out_data, 16'h0000);
    chk("arst_in_ready", in_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    model_reset();
    close_cycle();
    rst_n = 1'b1;
    drive(1'b0, 4'h0, 2'd0, MODE_RR, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("arst_cnt%0d", i), lane_cnt[i], 8'd0);
    close_cycle();

    // mixed mode: explicit capture must not advance the round-robin pointer
    drive(1'b1, 4'h1, 2'd0, MODE_RR, 4'hF, 1'b0);
    close_cycle();
    drive(1'b1, 4'h2, 2'd3, MODE_EXPLICIT, 4'hF, 1'b0);
    chk("mix_w1_valid", out_valid, 4'b0001);
    close_cycle();
    drive(1'b1, 4'h3, 2'd0, MODE_RR, 4'hF, 1'b0);
    chk("mix_w2_valid", out_valid, 4'b1000);
    close_cycle();
    drive(1'b0, 4'h0, 2'd0, MODE_RR, 4'hF, 1'b0);
    chk("mix_w3_valid", out_valid, 4'b0010);
    chk("mix_w3_data", out_data, 16'h0030);
    close_cycle();

    // HOLD ignores mode/dest changes and ready on other lanes
    drive(1'b1, 4'h9, 2'd1, MODE_EXPLICIT, 4'h0, 1'b0);
    close_cycle();
    c1_before = lane_cnt[1];
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 4'b1101, 1'b0);
      chk("hold_valid", out_valid, 4'b0010);
      chk("hold_data", out_data, 16'h0090);
      chk("hold_cnt1", lane_cnt[1], c1_before);
      close_cycle();
    end
    drive(1'b0, 4'h0, 2'd0, MODE_RR, 4'b0010, 1'b0);
    close_cycle();

    // saturation on narrow counter, then clear beats same-cycle increment
    drive(1'b0, 4'h0, 2'd0, MODE_RR, 4'hF, 1'b1);
    close_cycle();
    for (int i = 0; i < 6; i++) begin
      drive(i < 5, 4'(i + 1), 2'd1, MODE_EXPLICIT, 4'hF, 1'b0);
      close_cycle();
    end
    drive(1'b0, 4'h0, 2'd0, MODE_RR, 4'hF, 1'b0);
    chk("sat_s_cnt1", s_lane_cnt[1], 2'd3);
    chk("sat_cnt1", lane_cnt[1], 8'd5);
    close_cycle();
    drive(1'b1, 4'hE, 2'd1, MODE_EXPLICIT, 4'hF, 1'b0);
    close_cycle();
    drive(1'b0, 4'h0, 2'd0, MODE_RR, 4'hF, 1'b1);
    chk("clr_hs_valid", out_valid, 4'b0010);
    close_cycle();
    drive(1'b0, 4'h0, 2'd0, MODE_RR, 4'hF, 1'b0);
    chk("clr_s_cnt1", s_lane_cnt[1], 2'd0);
    chk("clr_cnt1", lane_cnt[1], 8'd0);
    close_cycle();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 31) == 0));
      close_cycle();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'h0, 2'd0, MODE_RR, 4'hF, 1'b0);
      close_cycle();
    end
    chk("scb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
